// File: rtl/xctcmsg_pkg.sv
// rtl/xctcmsg_pkg.sv - shared message, request and writeback types plus tag/address match helper
package xctcmsg_pkg;

   localparam int TAG_W  = 32;
   localparam int ADDR_W = 32;
   localparam int META_W = TAG_W + ADDR_W;
   localparam int DATA_W = 64;
   localparam int PT_W   = 8;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [ADDR_W-1:0] address;
      logic [DATA_W-1:0] data;
   } message_t;

   typedef message_t interface_receive_data_t;

   typedef struct packed {
      logic              is_avail;
      logic [META_W-1:0] meta;
      logic [META_W-1:0] meta_mask;
      logic [PT_W-1:0]   passthrough;
   } receive_queue_data_t;

   typedef struct packed {
      logic [DATA_W-1:0] value;
      logic [PT_W-1:0]   passthrough;
   } writeback_arbiter_data_t;

   typedef struct packed {
      message_t msg;
      logic     valid;
   } recv_slot_t;

   function automatic logic [META_W-1:0] message_meta(input message_t m);
      return {m.tag, m.address};
   endfunction

   // Mask bits set to 0 are wildcards.
   function automatic logic message_match(input logic [META_W-1:0] meta,
                                          input logic [META_W-1:0] req_meta,
                                          input logic [META_W-1:0] mask);
      return ((meta ^ req_meta) & mask) == '0;
   endfunction

endpackage

// File: rtl/xctcmsg_match_prio.sv
// rtl/xctcmsg_match_prio.sv - masked match across all slots with oldest-first one-hot winner
module xctcmsg_match_prio
   import xctcmsg_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic [DEPTH-1:0][META_W-1:0] slot_meta,
   input  logic [DEPTH-1:0]             slot_valid,
   input  logic [META_W-1:0]            req_meta,
   input  logic [META_W-1:0]            req_mask,
   output logic                         any_match,
   output logic [DEPTH-1:0]             winner
);

   logic [DEPTH-1:0] hit;

   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit[i] = slot_valid[i] && message_match(slot_meta[i], req_meta, req_mask);
      end
   end

   // Lowest set bit of hit: slot 0 is the oldest, so the oldest match wins.
   assign winner    = hit & (~hit + DEPTH'(1));
   assign any_match = |hit;

endmodule

// File: rtl/xctcmsg_receive_buffer.sv
// rtl/xctcmsg_receive_buffer.sv - age-ordered receive buffer serving RECV/AVAIL requests
// Optional XCTCMSG_RECV_DROP_ON_FULL_EN: never backpressure the network, count discarded messages.
module xctcmsg_receive_buffer
   import xctcmsg_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic                                       net_valid_i,
   output logic                                       net_ready_o,
   input  logic [$bits(interface_receive_data_t)-1:0] net_data_i,
   input  logic                                       req_valid_i,
   output logic                                       req_ready_o,
   input  logic [$bits(receive_queue_data_t)-1:0]     req_data_i,
   output logic                                       wb_valid_o,
   input  logic                                       wb_ready_i,
   output logic [$bits(writeback_arbiter_data_t)-1:0] wb_data_o,
   output logic [$clog2(DEPTH+1)-1:0]                 occupancy_o
`ifdef XCTCMSG_RECV_DROP_ON_FULL_EN
   ,
   output logic [15:0]                                drop_count_o
`endif
);

   localparam int OCC_W = $clog2(DEPTH+1);

   recv_slot_t                  slots   [DEPTH];
   recv_slot_t                  slots_n [DEPTH];
   logic [OCC_W-1:0]            occ;
   logic [OCC_W-1:0]            occ_n;
   logic [OCC_W-1:0]            occ_base;
   logic [DEPTH-1:0][META_W-1:0] slot_meta;
   logic [DEPTH-1:0]            slot_valid;
   logic [DEPTH-1:0]            winner;
   logic [DEPTH-1:0]            shift_en;
   logic                        seen;
   logic                        any_match;
   logic                        full;
   logic                        wb_free;
   logic                        req_accept;
   logic                        remove;
   logic                        insert;
   receive_queue_data_t         req;
   message_t                    net_msg;
   logic [DATA_W-1:0]           win_data;
   writeback_arbiter_data_t     wb_next;

   assign req     = req_data_i;
   assign net_msg = net_data_i;

   always_comb begin
      slot_meta  = '0;
      slot_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_meta[i]  = message_meta(slots[i].msg);
         slot_valid[i] = slots[i].valid;
      end
   end

   xctcmsg_match_prio #(
      .DEPTH (DEPTH)
   ) u_match_prio (
      .slot_meta  (slot_meta),
      .slot_valid (slot_valid),
      .req_meta   (req.meta),
      .req_mask   (req.meta_mask),
      .any_match  (any_match),
      .winner     (winner)
   );

   assign full        = (occ == OCC_W'(DEPTH));
   assign wb_free     = !wb_valid_o || wb_ready_i;
   assign req_ready_o = req_valid_i && wb_free && (req.is_avail || any_match);
   assign req_accept  = req_ready_o;
   assign remove      = req_accept && !req.is_avail;

`ifdef XCTCMSG_RECV_DROP_ON_FULL_EN
   assign net_ready_o = 1'b1;
   assign insert      = net_valid_i && !full;
`else
   assign net_ready_o = !full;
   assign insert      = net_valid_i && net_ready_o;
`endif

   // Winner data select and the mask of slots that close the gap left by the winner.
   always_comb begin
      win_data = '0;
      shift_en = '0;
      seen     = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (winner[i]) begin
            win_data = slots[i].msg.data;
         end
         seen        = seen | winner[i];
         shift_en[i] = seen;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slots_n[i] = slots[i];
      end
      if (remove) begin
         for (int i = 0; i < DEPTH-1; i++) begin
            if (shift_en[i]) begin
               slots_n[i] = slots[i+1];
            end
         end
         slots_n[DEPTH-1] = '0;
      end
      occ_base = remove ? occ - OCC_W'(1) : occ;
      occ_n    = occ_base;
      // A new arrival always lands just above the surviving entries.
      if (insert) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (OCC_W'(i) == occ_base) begin
               slots_n[i] = '{msg: net_msg, valid: 1'b1};
            end
         end
         occ_n = occ_base + OCC_W'(1);
      end
   end

   always_comb begin
      wb_next.value       = req.is_avail ? DATA_W'(any_match) : win_data;
      wb_next.passthrough = req.passthrough;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            slots[i] <= '0;
         end
         occ        <= '0;
         wb_valid_o <= 1'b0;
         wb_data_o  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            slots[i] <= slots_n[i];
         end
         occ <= occ_n;
         if (req_accept) begin
            wb_valid_o <= 1'b1;
            wb_data_o  <= wb_next;
         end else if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
         end
      end
   end

   assign occupancy_o = occ;

`ifdef XCTCMSG_RECV_DROP_ON_FULL_EN
   logic [15:0] drop_count;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_count <= '0;
      end else if (net_valid_i && full && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'd1;
      end
   end

   assign drop_count_o = drop_count;
`endif

endmodule

// File: tb/tb_xctcmsg_receive_buffer.sv
// tb/tb_xctcmsg_receive_buffer.sv - queue-model bench for xctcmsg_receive_buffer
`timescale 1ns/1ps
module tb_xctcmsg_receive_buffer;
   import xctcmsg_pkg::*;

   localparam int DEPTH = 8;
   localparam int OCC_W = $clog2(DEPTH+1);
   localparam logic [63:0] TAG_MASK = {32'hFFFF_FFFF, 32'h0000_0000};

   logic                                       clk = 1'b0;
   logic                                       rst;
   logic                                       net_valid;
   logic                                       net_ready;
   logic [$bits(interface_receive_data_t)-1:0] net_data;
   logic                                       req_valid;
   logic                                       req_ready;
   logic [$bits(receive_queue_data_t)-1:0]     req_data;
   logic                                       wb_valid;
   logic                                       wb_ready;
   logic [$bits(writeback_arbiter_data_t)-1:0] wb_data;
   logic [OCC_W-1:0]                           occupancy;
`ifdef XCTCMSG_RECV_DROP_ON_FULL_EN
   logic [15:0]                                drop_count;
`endif

   int checks = 0;
   int errors = 0;

   xctcmsg_receive_buffer #(.DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .net_valid_i (net_valid),
      .net_ready_o (net_ready),
      .net_data_i  (net_data),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_data_i  (req_data),
      .wb_valid_o  (wb_valid),
      .wb_ready_i  (wb_ready),
      .wb_data_o   (wb_data),
      .occupancy_o (occupancy)
`ifdef XCTCMSG_RECV_DROP_ON_FULL_EN
      ,
      .drop_count_o (drop_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference model: a plain FIFO-ordered list searched front to back.
   message_t                mq[$];
   logic                    m_wb_valid;
   writeback_arbiter_data_t m_wb;
   int                      m_drop;
   bit                      chk_en;

   initial begin : compare
      int                  hit;
      bit                  acc;
      bit                  exp_net_ready;
      receive_queue_data_t r;
      chk_en     = 0;
      m_wb_valid = 0;
      m_wb       = '0;
      m_drop     = 0;
      forever begin
         @(negedge clk);
         #4;
         r   = req_data;
         hit = -1;
         for (int i = 0; i < mq.size(); i++) begin
            if (hit < 0 && ((({mq[i].tag, mq[i].address}) ^ r.meta) & r.meta_mask) == 64'd0) hit = i;
         end
         acc = req_valid && (!m_wb_valid || wb_ready) && (r.is_avail || hit >= 0);
`ifdef XCTCMSG_RECV_DROP_ON_FULL_EN
         exp_net_ready = 1'b1;
`else
         exp_net_ready = (mq.size() < DEPTH);
`endif
         if (chk_en) begin
            check("occupancy", occupancy, mq.size());
            check("net_ready", net_ready, exp_net_ready);
            check("wb_valid", wb_valid, m_wb_valid);
            if (m_wb_valid) check("wb_data", wb_data, m_wb);
            check("req_ready", req_ready, acc);
`ifdef XCTCMSG_RECV_DROP_ON_FULL_EN
            check("drop_count", drop_count, m_drop);
`endif
         end
         if (rst) begin
            mq.delete();
            m_wb_valid = 0;
            m_wb       = '0;
            m_drop     = 0;
            chk_en     = 1;
         end else if (chk_en) begin
            bit was_full;
            was_full = (mq.size() >= DEPTH);
            if (acc) begin
               if (r.is_avail) begin
                  m_wb.value = (hit >= 0) ? 64'd1 : 64'd0;
               end else begin
                  m_wb.value = mq[hit].data;
                  mq.delete(hit);
               end
               m_wb.passthrough = r.passthrough;
               m_wb_valid       = 1;
            end else if (wb_ready) begin
               m_wb_valid = 0;
            end
            if (net_valid) begin
               if (!was_full) mq.push_back(message_t'(net_data));
               else if (m_drop < 65535) m_drop++;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_msg(input logic [31:0] tag, input logic [31:0] addr, input logic [63:0] data);
      message_t m;
      logic     acc;
      int       n;
      m.tag     = tag;
      m.address = addr;
      m.data    = data;
      net_data  = m;
      net_valid = 1;
      acc = 0;
      n   = 0;
      while (!acc && n < 50) begin
         #3;
         acc = net_ready;
         tick();
         n++;
      end
      net_valid = 0;
      check("send_accept", acc, 1'b1);
   endtask

   task automatic req_start(input logic is_avail, input logic [63:0] meta,
                            input logic [63:0] mask, input logic [7:0] pt);
      receive_queue_data_t r;
      r.is_avail    = is_avail;
      r.meta        = meta;
      r.meta_mask   = mask;
      r.passthrough = pt;
      req_data  = r;
      req_valid = 1;
   endtask

   task automatic req_wait();
      logic acc;
      int   n;
      acc = 0;
      n   = 0;
      while (!acc && n < 50) begin
         #3;
         acc = req_ready;
         tick();
         n++;
      end
      req_valid = 0;
      check("req_accept", acc, 1'b1);
   endtask

   task automatic request(input logic is_avail, input logic [63:0] meta,
                          input logic [63:0] mask, input logic [7:0] pt);
      req_start(is_avail, meta, mask, pt);
      req_wait();
   endtask

   task automatic check_wb(input string name, input logic [63:0] value, input logic [7:0] pt);
      check({name, "_valid"}, wb_valid, 1'b1);
      check(name, wb_data, {value, pt});
   endtask

   initial begin : stimulus
      message_t m;
      rst       = 1;
      net_valid = 0;
      net_data  = '0;
      req_valid = 0;
      req_data  = '0;
      wb_ready  = 1;
      repeat (3) @(negedge clk);
      #1;
      rst = 0;
      check("reset_occupancy", occupancy, 0);
      check("reset_wb_valid", wb_valid, 1'b0);
      check("reset_wb_data", wb_data, 0);
      check("reset_net_ready", net_ready, 1'b1);
      check("reset_req_ready", req_ready, 1'b0);

      send_msg(32'h10, 32'h1, 64'hAA);
      check("single_occ_before", occupancy, 1);
      request(0, {32'h10, 32'h1}, '1, 8'h01);
      check_wb("single_recv", 64'hAA, 8'h01);
      check("single_occ_after", occupancy, 0);

      send_msg(32'h5, 32'h0, 64'h1);
      send_msg(32'h5, 32'h0, 64'h2);
      request(0, {32'h5, 32'h0}, TAG_MASK, 8'h02);
      check_wb("oldest_first_a", 64'h1, 8'h02);
      request(0, {32'h5, 32'h0}, TAG_MASK, 8'h03);
      check_wb("oldest_first_b", 64'h2, 8'h03);

      request(1, {32'h7, 32'h0}, TAG_MASK, 8'h04);
      check_wb("avail_empty", 64'h0, 8'h04);
      check("avail_empty_occ", occupancy, 0);
      send_msg(32'h7, 32'h0, 64'h77);
      request(1, {32'h7, 32'h0}, TAG_MASK, 8'h05);
      check_wb("avail_hit", 64'h1, 8'h05);
      check("avail_hit_occ", occupancy, 1);
      request(0, {32'h7, 32'h0}, TAG_MASK, 8'h06);
      check_wb("avail_drain", 64'h77, 8'h06);

      send_msg(32'h21, 32'h0, 64'hB1);
      send_msg(32'h22, 32'h0, 64'hB2);
      send_msg(32'h23, 32'h0, 64'hB3);
      request(0, 64'h0, 64'h0, 8'h07);
      check_wb("wildcard", 64'hB1, 8'h07);
      check("wildcard_occ", occupancy, 2);
      request(0, {32'h22, 32'h0}, TAG_MASK, 8'h08);
      check_wb("after_shift", 64'hB2, 8'h08);
      request(0, 64'h0, 64'h0, 8'h09);
      check_wb("after_shift_last", 64'hB3, 8'h09);

      req_start(0, {32'h99, 32'h0}, TAG_MASK, 8'h0A);
      repeat (4) tick();
      check("stall_req_ready", req_ready, 1'b0);
      send_msg(32'h99, 32'h0, 64'h999);
      req_wait();
      check_wb("stall_release", 64'h999, 8'h0A);

      for (int i = 0; i < DEPTH; i++) send_msg(32'h40 + i, 32'h0, 64'h100 + i);
      check("full_occ", occupancy, DEPTH);
`ifdef XCTCMSG_RECV_DROP_ON_FULL_EN
      check("full_net_ready", net_ready, 1'b1);
`else
      check("full_net_ready", net_ready, 1'b0);
`endif
      wb_ready = 0;
      request(1, {32'h40, 32'h0}, TAG_MASK, 8'h11);
      check_wb("bp_first", 64'h1, 8'h11);
      req_start(1, {32'h41, 32'h0}, TAG_MASK, 8'h12);
      repeat (3) tick();
      check("bp_req_ready", req_ready, 1'b0);
      check_wb("bp_hold", 64'h1, 8'h11);
      wb_ready = 1;
      req_wait();
      check_wb("bp_next", 64'h1, 8'h12);

      m.tag = 32'h50; m.address = 32'h0; m.data = 64'h150;
      net_data  = m;
      net_valid = 1;
      req_start(0, {32'h43, 32'h0}, TAG_MASK, 8'h13);
      tick();
      net_valid = 0;
      req_valid = 0;
      check("full_recv_insert_occ", occupancy, DEPTH - 1);
      check_wb("full_recv", 64'h103, 8'h13);

      m.tag = 32'h51; m.address = 32'h0; m.data = 64'h151;
      net_data  = m;
      net_valid = 1;
      req_start(0, {32'h44, 32'h0}, TAG_MASK, 8'h14);
      tick();
      net_valid = 0;
      req_valid = 0;
      check("swap_occ", occupancy, DEPTH - 1);
      check_wb("swap_recv", 64'h104, 8'h14);
      for (int k = 0; k < DEPTH - 1; k++) request(0, 64'h0, 64'h0, 8'h20 + 8'(k));
      check_wb("drain_last_on_top", 64'h151, 8'h26);
      check("drain_occ", occupancy, 0);

      send_msg(32'h60, 32'h0, 64'h160);
      wb_ready = 0;
      request(1, {32'h60, 32'h0}, TAG_MASK, 8'h30);
      check("midreset_pending", wb_valid, 1'b1);
      rst = 1;
      tick();
      rst = 0;
      wb_ready = 1;
      check("midreset_wb_valid", wb_valid, 1'b0);
      check("midreset_occ", occupancy, 0);
      check("midreset_wb_data", wb_data, 0);

      for (int i = 0; i < DEPTH; i++) send_msg(32'h70 + i, 32'h0, 64'h200 + i);
      m.tag = 32'h7F; m.address = 32'h0; m.data = 64'h2FF;
      net_data  = m;
      net_valid = 1;
      repeat (3) tick();
      net_valid = 0;
      check("overflow_occ", occupancy, DEPTH);
`ifdef XCTCMSG_RECV_DROP_ON_FULL_EN
      check("overflow_drop_count", drop_count, 3);
`endif
      for (int k = 0; k < DEPTH; k++) request(0, 64'h0, 64'h0, 8'h40 + 8'(k));
      check_wb("overflow_last", 64'h207, 8'h47);

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

endmodule

// File: doc/xctcmsg_receive_buffer.md
Name: xctcmsg_receive_buffer

Overview:
- Receive-side endpoint of the xctcmsg message extension.
- Buffers messages arriving from the network interface (interface_receive_data_t) and serves RECV/AVAIL requests popped from the receive queue (receive_queue_data_t).
- Selection is by masked tag/address match.
- Results go to the writeback arbiter (writeback_arbiter_data_t). It is the consumer counterpart of the send queue / interface send path.

Parameters:
- DEPTH, 8: number of message slots (2..32).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- net_valid_i  in  1  incoming message valid
- net_ready_o  out  1  buffer can accept a message
- net_data_i  in  $bits(interface_receive_data_t)  incoming message (tag, address, data)
- req_valid_i  in  1  receive-queue request valid
- req_ready_o  out  1  request accepted this cycle
- req_data_i  in  $bits(receive_queue_data_t)  is_avail, meta, meta_mask, passthrough
- wb_valid_o  out  1  writeback result valid
- wb_ready_i  in  1  arbiter takes result
- wb_data_o  out  $bits(writeback_arbiter_data_t)  value, passthrough
- occupancy_o  out  $clog2(DEPTH+1)  number of stored messages

Behaviour:
- Reset: all slots invalid, occupancy_o=0, wb_valid_o=0, wb_data_o=0. net_ready_o=1 and req_ready_o=0 in the first cycle after reset.
- Storage: age-ordered compacting array. Slot 0 is the oldest; valid slots are contiguous, 0..occupancy-1.
- Match of slot i: ((slot.meta ^ req.meta) & req.meta_mask) == 0, evaluated over the 64-bit tag|address. Winner is the lowest-index match (oldest first).
- Output register free: wb_free = !wb_valid_o || wb_ready_i.
- Accepting a message:
  - net_ready_o = (occupancy < DEPTH), from registered state only.
  - On net_valid_i && net_ready_o, the message is written at index occupancy - removed_this_cycle.
  - A newly accepted message is not visible to matching until the next cycle.
- RECV (is_avail=0):
  - req_ready_o = req_valid_i && wb_free && any_match.
  - On accept: winner slot removed, higher slots shift down one.
  - Next cycle: wb_valid_o=1, value = winner data, passthrough copied from the request.
  - With no match, RECV stalls (req_ready_o=0). No timeout.
- AVAIL (is_avail=1):
  - req_ready_o = req_valid_i && wb_free.
  - Next cycle: value = 64'd1 if any_match else 64'd0. No removal.
- Latency: exactly one cycle from request accept to wb_valid_o.
- Output register: wb_valid_o holds until wb_ready_i. Back-to-back requests are allowed when wb_ready_i=1 (full throughput).
- Simultaneous insert and RECV removal at occupancy=DEPTH: no insert, because net_ready_o is already 0 that cycle. Occupancy becomes DEPTH-1.
- Simultaneous insert and removal below DEPTH: occupancy is unchanged and the new message lands at the top.
- Reset mid-operation: the buffer is emptied, and a pending writeback is dropped (wb_valid_o=0 next cycle).
- Stability: req_data_i must be stable while req_valid_i=1 and not accepted. net_data_i is captured only on its handshake.

Optional Feature:
- Macro: XCTCMSG_RECV_DROP_ON_FULL_EN.
- Defined:
  - net_ready_o is tied to 1.
  - A message arriving while occupancy==DEPTH is discarded.
  - Extra port drop_count_o (out, 16) counts discards, saturating at 16'hFFFF, reset to 0.
- Undefined: backpressure as specified above, and drop_count_o does not exist.

Decomposition:
- Add to xctcmsg_pkg:
  - a message_match function (meta, req meta, mask -> logic);
  - a typedef recv_slot_t (message_t, valid).
- One sub-module: xctcmsg_match_prio. It is combinational and takes DEPTH slot metas, the request meta and the mask. It outputs any_match and a one-hot/index winner (lowest index).

Test Plan:
- Insert tag=0x10/addr=0x1/data=0xAA, then RECV with meta tag=0x10, mask all-ones -> req accepted, next cycle wb value=0xAA, occupancy 1->0.
- Insert tags 0x5 (data 0x1) then 0x5 (data 0x2); RECV tag=0x5 -> value 0x1 first, then a second RECV gives 0x2 (oldest-first).
- AVAIL tag=0x7 on an empty buffer -> value 0, occupancy unchanged. Insert tag 0x7, then AVAIL -> value 1, occupancy stays 1.
- Wildcard: mask=0 with RECV and three stored messages -> slot 0 returned, remaining two shift down.
- Full/backpressure: fill to DEPTH=8 -> net_ready_o=0. Hold wb_ready_i=0 with a result pending -> req_ready_o=0, wb_data_o stable. RECV while full with an insert offered -> occupancy 7.
- With XCTCMSG_RECV_DROP_ON_FULL_EN: fill to 8, offer 3 more -> drop_count_o=3, stored contents unchanged.
